// File: rtl/tetris_control_pkg.sv
// Shared engine command encoding used by everything that talks to the tetris engine.
package tetris_control_pkg;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        LEFT   = 3'd1,
        RIGHT  = 3'd2,
        DOWN   = 3'd3,
        ROTATE = 3'd4,
        DROP   = 3'd5
    } control_type;

endpackage

// File: rtl/tetris_input_sequencer_pkg.sv
// Sequencer state encoding and the gravity period helper.
package tetris_input_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_HOLDOFF
    } seq_state_t;

    // A level high enough to shift the period to zero still ticks every cycle.
    function automatic int unsigned gravity_period(input int unsigned ticks, input logic [2:0] level);
        int unsigned period;
        period = ticks >> level;
        return (period == 0) ? 1 : period;
    endfunction

endpackage

// File: rtl/tetris_input_sequencer_cmd_fifo.sv
// Synchronous FIFO with flush; generic width so it can also carry UART key codes.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // NOTE: storage has no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tetris_input_sequencer.sv
// Turns user command pulses and a gravity timer into a one-cycle-per-command ctrl stream.
module tetris_input_sequencer
    import tetris_control_pkg::*;
    import tetris_input_sequencer_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int GRAVITY_TICKS = 50_000_000,
    parameter int TIMEOUT       = 4096
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    input  control_type              cmd,
    input  logic                     start,
    input  logic [2:0]               level,
    input  logic                     ready,
    output control_type              ctrl,
    output logic                     playing,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               dropped
);

    localparam int GW = (GRAVITY_TICKS > 1) ? $clog2(GRAVITY_TICKS) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int CW = $bits(control_type);

    seq_state_t      state, state_next;
    control_type     ctrl_next;
    logic [GW-1:0]   grav_cnt;
    logic [GW-1:0]   grav_limit;
    logic            grav_pending;
    logic            grav_tick;
    logic            issue_grav;
    logic [TW-1:0]   tout_cnt;
    logic            timed_out;
    logic            counting;
    logic            fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_rdata;
    logic            drop;

    assign counting   = (state == ST_RUN) || (state == ST_HOLDOFF);
    assign playing    = counting;
    assign grav_limit = GW'(gravity_period(GRAVITY_TICKS, level) - 1);
    assign grav_tick  = counting && (grav_cnt == grav_limit);
    assign fifo_push  = cmd_valid && (cmd != NONE) && (counting || state == ST_START) && !fifo_flush;
    assign drop       = fifo_push && fifo_full && !fifo_pop;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        ctrl_next  = NONE;
        issue_grav = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        timed_out  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_START;
                    ctrl_next  = DOWN;
                end else if (ready) begin
                    state_next = ST_RUN;
                end
            end
            ST_START: state_next = ST_RUN;
            ST_RUN: begin
                if (start) begin
                    state_next = ST_START;
                    ctrl_next  = DOWN;
                    fifo_flush = 1'b1;
                end else if (ready) begin
                    if (grav_pending) begin
                        state_next = ST_HOLDOFF;
                        ctrl_next  = DOWN;
                        issue_grav = 1'b1;
                    end else if (!fifo_empty) begin
                        state_next = ST_HOLDOFF;
                        ctrl_next  = control_type'(fifo_rdata);
                        fifo_pop   = 1'b1;
                    end
                end else if (tout_cnt == TW'(TIMEOUT - 1)) begin
                    state_next = ST_IDLE;
                    fifo_flush = 1'b1;
                    timed_out  = 1'b1;
                end
            end
            ST_HOLDOFF: state_next = ST_RUN;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            ctrl         <= NONE;
            grav_cnt     <= '0;
            grav_pending <= 1'b0;
            tout_cnt     <= '0;
            dropped      <= '0;
        end else begin
            state <= state_next;
            ctrl  <= ctrl_next;

            if (state == ST_START) begin
                grav_cnt     <= '0;
                grav_pending <= 1'b0;
                tout_cnt     <= '0;
            end else begin
                // Counter above a freshly lowered limit simply rolls over at all-ones.
                if (counting) grav_cnt <= grav_tick ? '0 : grav_cnt + 1'b1;

                if (timed_out)       grav_pending <= 1'b0;
                else if (grav_tick)  grav_pending <= 1'b1;
                else if (issue_grav) grav_pending <= 1'b0;

                if (state == ST_HOLDOFF)                     tout_cnt <= tout_cnt + 1'b1;
                else if (state == ST_RUN && (ready || timed_out)) tout_cnt <= '0;
                else if (state == ST_RUN)                    tout_cnt <= tout_cnt + 1'b1;
            end

            if (drop && dropped != 8'hFF) dropped <= dropped + 1'b1;
        end
    end

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CW)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .wdata   (CW'(cmd)),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_tetris_input_sequencer.sv
// Directed scenarios plus a randomized run scored against a queue-based model of the sequencer.
module tb_tetris_input_sequencer;
    import tetris_control_pkg::*;

    localparam int DEPTH = 4;
    localparam int GT    = 16;
    localparam int TO    = 32;
    localparam int GMOD  = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    control_type cmd = NONE;
    logic        start = 1'b0;
    logic [2:0]  level = 3'd0;
    logic        ready = 1'b0;
    control_type ctrl;
    logic        playing;
    logic [2:0]  fifo_count;
    logic [7:0]  dropped;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tetris_input_sequencer #(
        .DEPTH(DEPTH), .GRAVITY_TICKS(GT), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd(cmd), .start(start),
        .level(level), .ready(ready), .ctrl(ctrl), .playing(playing),
        .fifo_count(fifo_count), .dropped(dropped)
    );

    // Behavioural model: game phase, queued commands, plain integer timers.
    typedef enum int {M_IDLE, M_START, M_RUN, M_HOLD} mode_t;
    mode_t       m_mode;
    control_type m_q[$];
    control_type m_ctrl;
    int          m_gcnt, m_tcnt, m_drop;
    bit          m_pend;

    task automatic model_reset();
        m_mode = M_IDLE; m_q.delete(); m_ctrl = NONE;
        m_gcnt = 0; m_tcnt = 0; m_drop = 0; m_pend = 0;
    endtask

    task automatic model_step();
        mode_t       nm = m_mode;
        control_type nc = NONE;
        bit flush = 0, tick, issue_g = 0, tout = 0, active;
        int per;
        per = GT >> int'(level);
        if (per == 0) per = 1;
        active = (m_mode == M_RUN) || (m_mode == M_HOLD);
        tick = active && (m_gcnt == per - 1);
        case (m_mode)
            M_IDLE:  if (start) begin nm = M_START; nc = DOWN; end
                     else if (ready) nm = M_RUN;
            M_START: nm = M_RUN;
            M_RUN: begin
                if (start) begin nm = M_START; nc = DOWN; flush = 1; end
                else if (ready) begin
                    m_tcnt = 0;
                    if (m_pend) begin nc = DOWN; issue_g = 1; nm = M_HOLD; end
                    else if (m_q.size() > 0) begin nc = m_q.pop_front(); nm = M_HOLD; end
                end else if (m_tcnt == TO - 1) begin
                    nm = M_IDLE; flush = 1; tout = 1; m_tcnt = 0;
                end else m_tcnt++;
            end
            M_HOLD: begin nm = M_RUN; m_tcnt++; end
        endcase
        if (active) m_gcnt = tick ? 0 : (m_gcnt + 1) % GMOD;
        if (tout)         m_pend = 0;
        else if (tick)    m_pend = 1;
        else if (issue_g) m_pend = 0;
        if ((active || m_mode == M_START) && cmd_valid && cmd != NONE && !flush) begin
            if (m_q.size() < DEPTH) m_q.push_back(cmd);
            else if (m_drop < 255) m_drop++;
        end
        if (flush) m_q.delete();
        if (m_mode == M_START) begin m_gcnt = 0; m_pend = 0; m_tcnt = 0; end
        m_mode = nm;
        m_ctrl = nc;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ctrl !== NONE || playing !== 1'b0 || fifo_count !== 3'd0 || dropped !== 8'd0) begin
            n_errors++;
            $display("FAIL reset: ctrl=%0d playing=%0b count=%0d dropped=%0d want 0 0 0 0",
                     ctrl, playing, fifo_count, dropped);
        end
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (ctrl !== DOWN || playing !== 1'b0) begin
            n_errors++;
            $display("FAIL start_issue: ctrl=%0d playing=%0b want DOWN 0", ctrl, playing);
        end
        tick();
        n_checks++;
        if (ctrl !== NONE || playing !== 1'b1) begin
            n_errors++;
            $display("FAIL start_run: ctrl=%0d playing=%0b want NONE 1", ctrl, playing);
        end
    endtask

    task automatic test_gravity();
        int last = -1;
        int n_down = 0;
        ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (ctrl == DOWN) begin
                if (last >= 0) begin
                    n_checks++;
                    if (i - last !== GT) begin
                        n_errors++;
                        $display("FAIL gravity_period: got %0d cycles want %0d", i - last, GT);
                    end
                end
                last = i;
                n_down++;
            end
        end
        n_checks++;
        if (n_down < 3) begin
            n_errors++;
            $display("FAIL gravity_count: got %0d DOWNs want at least 3", n_down);
        end
    endtask

    // Leaves the bench just after a gravity DOWN, so the next tick is a known 15 edges away.
    task automatic sync_gravity();
        bit seen = 0;
        ready = 1'b1; cmd_valid = 1'b0; start = 1'b0; level = 3'd0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (ctrl == DOWN) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL sync_gravity: no DOWN within 40 cycles");
        end
    endtask

    task automatic test_fifo_order();
        control_type exp_seq [5] = '{LEFT, NONE, ROTATE, NONE, RIGHT};
        control_type pushes [3] = '{LEFT, ROTATE, RIGHT};
        sync_gravity();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd = pushes[i];
            tick();
        end
        cmd_valid = 1'b0; cmd = NONE;
        n_checks++;
        if (fifo_count !== 3'd3) begin
            n_errors++;
            $display("FAIL fifo_fill: count=%0d want 3", fifo_count);
        end
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (ctrl !== exp_seq[i]) begin
                n_errors++;
                $display("FAIL fifo_order[%0d]: ctrl=%0d want %0d", i, ctrl, exp_seq[i]);
            end
        end
        n_checks++;
        if (fifo_count !== 3'd0) begin
            n_errors++;
            $display("FAIL fifo_drain: count=%0d want 0", fifo_count);
        end
    endtask

    task automatic test_overflow();
        control_type pushes [6] = '{DROP, LEFT, RIGHT, ROTATE, LEFT, DOWN};
        control_type got[$];
        sync_gravity();
        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1; cmd = pushes[i];
            tick();
        end
        cmd_valid = 1'b0; cmd = NONE;
        n_checks++;
        if (fifo_count !== 3'd4 || dropped !== 8'd2) begin
            n_errors++;
            $display("FAIL overflow: count=%0d dropped=%0d want 4 2", fifo_count, dropped);
        end
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ctrl != NONE) got.push_back(ctrl);
        end
        n_checks++;
        if (got.size() !== 4) begin
            n_errors++;
            $display("FAIL overflow_issued: got %0d commands want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got[i] !== pushes[i]) begin
                    n_errors++;
                    $display("FAIL overflow_order[%0d]: ctrl=%0d want %0d", i, got[i], pushes[i]);
                end
            end
        end
    endtask

    task automatic test_priority();
        control_type exp_seq [3] = '{DOWN, NONE, LEFT};
        sync_gravity();
        ready = 1'b0;
        cmd_valid = 1'b1; cmd = LEFT;
        tick();
        cmd_valid = 1'b0; cmd = NONE;
        repeat (14) tick();
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (ctrl !== exp_seq[i]) begin
                n_errors++;
                $display("FAIL priority[%0d]: ctrl=%0d want %0d", i, ctrl, exp_seq[i]);
            end
        end
    endtask

    task automatic test_coalesce();
        control_type exp_seq [3] = '{DOWN, NONE, NONE};
        sync_gravity();
        level = 3'd2;
        ready = 1'b0;
        repeat (12) tick();
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (ctrl !== exp_seq[i]) begin
                n_errors++;
                $display("FAIL coalesce[%0d]: ctrl=%0d want %0d", i, ctrl, exp_seq[i]);
            end
        end
        level = 3'd0;
    endtask

    task automatic test_timeout();
        sync_gravity();
        ready = 1'b0;
        cmd_valid = 1'b1; cmd = RIGHT;
        tick();
        cmd_valid = 1'b0; cmd = NONE;
        n_checks++;
        if (fifo_count !== 3'd1) begin
            n_errors++;
            $display("FAIL timeout_push: count=%0d want 1", fifo_count);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            n_checks++;
            if (ctrl !== NONE || playing !== 1'b1) begin
                n_errors++;
                $display("FAIL timeout_wait[%0d]: ctrl=%0d playing=%0b want NONE 1", i, ctrl, playing);
            end
        end
        tick();
        n_checks++;
        if (playing !== 1'b0 || fifo_count !== 3'd0 || ctrl !== NONE) begin
            n_errors++;
            $display("FAIL timeout_idle: playing=%0b count=%0d ctrl=%0d want 0 0 NONE",
                     playing, fifo_count, ctrl);
        end
        repeat (3) tick();
        n_checks++;
        if (playing !== 1'b0 || ctrl !== NONE) begin
            n_errors++;
            $display("FAIL timeout_stay: playing=%0b ctrl=%0d want 0 NONE", playing, ctrl);
        end
    endtask

    task automatic test_random();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 800; i++) begin
            start     = ($urandom_range(0, 59) == 0);
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd       = control_type'($urandom_range(0, 5));
            ready     = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0) level = 3'($urandom_range(0, 7));
            tick();
            n_checks++;
            if (ctrl !== m_ctrl || playing !== (m_mode == M_RUN || m_mode == M_HOLD) ||
                int'(fifo_count) !== m_q.size() || int'(dropped) !== m_drop) begin
                n_errors++;
                $display("FAIL random[%0d]: ctrl=%0d/%0d playing=%0b/%0b count=%0d/%0d dropped=%0d/%0d",
                         i, ctrl, m_ctrl, playing, (m_mode == M_RUN || m_mode == M_HOLD),
                         fifo_count, m_q.size(), dropped, m_drop);
            end
        end
        start = 1'b0; cmd_valid = 1'b0; cmd = NONE; level = 3'd0;
    endtask

    task automatic test_reset_holdoff();
        bit seen = 0;
        ready = 1'b1; cmd_valid = 1'b1; cmd = LEFT;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (ctrl != NONE) seen = 1;
        end
        cmd_valid = 1'b0; cmd = NONE;
        n_checks++;
        if (!seen || playing !== 1'b1) begin
            n_errors++;
            $display("FAIL holdoff_reach: seen=%0b playing=%0b want 1 1", seen, playing);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== NONE || playing !== 1'b0 || fifo_count !== 3'd0 || dropped !== 8'd0) begin
            n_errors++;
            $display("FAIL async_reset: ctrl=%0d playing=%0b count=%0d dropped=%0d want 0 0 0 0",
                     ctrl, playing, fifo_count, dropped);
        end
        model_reset();
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_gravity();
        test_fifo_order();
        test_overflow();
        test_priority();
        test_coalesce();
        test_timeout();
        test_random();
        test_reset_holdoff();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tetris_input_sequencer.md
Name: tetris_input_sequencer

Overview:
- Initiator side of the `control_type` command interface into the tetris game engine.
- Turns single-cycle user command pulses and an internal gravity timer into a legal `ctrl` stream.
- Each command is presented for exactly one cycle, and only while the engine's `ready` is high. Commands are buffered in a small FIFO.
- Watches for engine inactivity (INIT/END or stuck) and needs an explicit start to resume issuing.

Parameters:
- DEPTH, 4: command FIFO entries; must be a power of two, at least 2.
- GRAVITY_TICKS, 50_000_000: clock cycles between automatic DOWN commands at level 0.
- TIMEOUT, 4096: consecutive `ready`-low cycles in RUN before the engine is declared idle.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  one-cycle pulse: `cmd` is a new user command
- cmd  in  control_type  user command; NONE is ignored even when `cmd_valid` is high
- start  in  1  one-cycle pulse: start or restart the game
- level  in  3  speed level; gravity period = GRAVITY_TICKS >> level
- ready  in  1  engine ready (engine is in WAIT)
- ctrl  out  control_type  command to the engine; NONE except during an issue cycle
- playing  out  1  high in RUN and HOLDOFF
- fifo_count  out  $clog2(DEPTH)+1  number of queued commands
- dropped  out  8  saturating count of commands lost to a full FIFO

Behaviour:
- Reset (asynchronous, active-low) gives:
  - state IDLE, `ctrl` = NONE, `playing` 0
  - FIFO empty, `fifo_count` 0, `dropped` 0
  - gravity counter 0, gravity pending 0, timeout counter 0
- `ctrl` is registered: it takes its value on the same edge at which the issue decision is made, and is NONE on every other cycle.
- States: IDLE, START, RUN, HOLDOFF.
- IDLE:
  - `start` -> START.
  - `ready` high (engine already in WAIT after a sequencer-only reset) -> RUN, with no command issued.
  - `cmd_valid` is ignored; the FIFO stays empty.
- START:
  - Drives `ctrl` = DOWN for one cycle; any non-NONE value moves the engine from INIT or END toward GEN.
  - Clears gravity counter, gravity pending and timeout counter.
  - Next state is RUN.
- RUN:
  - If `ready` = 1 and (gravity pending or FIFO non-empty), issue one command and go to HOLDOFF.
  - Gravity pending has priority over the FIFO head. Issuing gravity clears the pending flag; issuing from the FIFO pops the head.
  - If `ready` = 0, the timeout counter increments; any `ready` = 1 cycle clears it.
  - At timeout counter == TIMEOUT-1 with `ready` still 0: go to IDLE, flush the FIFO, clear gravity pending.
  - A `start` pulse in RUN goes to START and flushes the FIFO (restart path; the engine in END accepts DOWN).
- HOLDOFF:
  - Exactly one cycle; `ctrl` = NONE. This guarantees no back-to-back issue even if `ready` is sampled stale.
  - Next state is RUN.
  - Counts toward timeout exactly as a `ready`-low cycle does.
- Gravity:
  - Counter runs only in RUN and HOLDOFF.
  - When it reaches (GRAVITY_TICKS >> level)-1 it wraps to 0 and sets gravity pending.
  - A tick while pending is already set is coalesced: the flag stays set, no second DOWN is generated.
  - A `level` change takes effect at the next compare. If the counter is already above the new limit, it wraps at its all-ones value. A computed period of 0 is treated as 1.
- FIFO enqueue:
  - Enqueue when `cmd_valid` is high, `cmd` is not NONE, and state is RUN, HOLDOFF or START.
  - If the FIFO is full and no pop occurs that cycle, the command is dropped and `dropped` increments, saturating at 255.
  - Simultaneous push and pop when full is accepted; the count is unchanged.
  - Push and pop when empty: the pushed entry is not issued in the same cycle; it is issued at the earliest on the next RUN cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally; `fifo_count` saturates at DEPTH.
- `start` and `cmd_valid` together in IDLE: `start` wins and the command is discarded.

Decomposition:
- `control_type` comes from the shared control header and is not redefined here.
- A shared package holds the sequencer state enum and a function returning the gravity period with the period-0 clamp.
- One natural sub-module: `cmd_fifo`, a synchronous FIFO with DEPTH and width parameters and push/pop/full/empty/count signals, reusable for a UART key path.

Test Plan:
- Use GRAVITY_TICKS=16, TIMEOUT=32 in the bench.
- Start from IDLE: pulse `start` -> `ctrl`=DOWN for exactly 1 cycle, 1 cycle after `start`; `playing`=1 on the next cycle. Then hold `ready`=1 with no commands -> DOWN every 16 cycles.
- Push LEFT, ROTATE, RIGHT with `ready`=0, then raise `ready` permanently -> `fifo_count` 3, then `ctrl` sequence LEFT, NONE, ROTATE, NONE, RIGHT on consecutive cycles; `fifo_count` ends at 0.
- Push 6 commands while `ready`=0 with DEPTH=4 -> `fifo_count`=4, `dropped`=2; the first 4 commands are issued in order once `ready`=1.
- Gravity tick at the same cycle a FIFO command is ready, with `ready`=1 -> DOWN is issued first, then the queued command after HOLDOFF. Three ticks elapse with `ready`=0 -> only one DOWN is issued once `ready` rises.
- Hold `ready`=0 for 32 cycles in RUN -> state IDLE, `playing`=0, FIFO flushed, `ctrl` stays NONE. Assert `reset_n` low mid-HOLDOFF -> all outputs immediately at reset values.
